// File: rtl/div32x16_seq.sv
// div32x16_seq
//   Sequential unsigned divider: 32-bit dividend / 16-bit divisor.
//   It produces a 16-bit quotient and a 16-bit remainder using a restoring
//   shift-subtract algorithm, one quotient bit per clock.
//   Latency from an accepted start to done is 17 edges on the normal path
//   and 2 edges on the overflow path.
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-high reset; clears all state
//   dividend   in  32   numerator, sampled on an accepted start
//   divisor    in  16   denominator, sampled on an accepted start
//   start      in   1   operation request
//   quotient   out 16   registered result, held until the next done
//   remainder  out 16   registered result, held until the next done
//   overflow   out  1   quotient does not fit in 16 bits (includes divisor == 0)
//   busy       out  1   iteration phase in progress
//   done       out  1   one-cycle pulse: quotient/remainder/overflow valid
//
// Configuration
//   DIV32X16_BUSY_RESTART_EN : when defined, start is accepted in every state.
//                              The running operation is abandoned and the new
//                              operands are loaded. When undefined, start is
//                              honoured only in IDLE.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start
// CHECK | overflow test on the latched operands
// DIV   | 16 shift-subtract iterations (busy)
// DONE  | done pulse, results valid; returns to IDLE

module div32x16_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    input  logic        start,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        overflow,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_DIV   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // The working register W is held as its two halves. p_reg starts as
    // W[31:16] and becomes the partial remainder. l_reg starts as W[15:0]
    // and collects the quotient bits as the dividend bits shift out.
    logic [15:0] p_reg;
    logic [15:0] l_reg;
    logic [15:0] d_reg;
    logic [3:0]  cnt;
    logic        ovf_pend;
    logic        accept;

    logic [16:0] t_val;
    logic        q_bit;
    logic [15:0] p_next;

    assign t_val  = {p_reg, l_reg[15]};
    assign q_bit  = (t_val >= {1'b0, d_reg});
    // P < D holds on entry to every iteration, so T - D always fits in 16 bits.
    assign p_next = q_bit ? 16'(t_val - {1'b0, d_reg}) : t_val[15:0];

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
`ifdef DIV32X16_BUSY_RESTART_EN
        accept    = start;
`else
        accept    = start && (state == S_IDLE);
`endif
        case (state)
            S_IDLE:  state_nxt = S_IDLE;
            S_CHECK: state_nxt = S_DIV;
            S_DIV: begin
                busy = 1'b1;
                if (cnt == 4'd15)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (accept)
            state_nxt = S_CHECK;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_reg     <= 16'd0;
            l_reg     <= 16'd0;
            d_reg     <= 16'd0;
            cnt       <= 4'd0;
            ovf_pend  <= 1'b0;
            quotient  <= 16'd0;
            remainder <= 16'd0;
            overflow  <= 1'b0;
        end else if (accept) begin
            p_reg    <= dividend[31:16];
            l_reg    <= dividend[15:0];
            d_reg    <= divisor;
            cnt      <= 4'd0;
            ovf_pend <= 1'b0;
        end else begin
            case (state)
                S_CHECK: begin
                    // On overflow the iteration is skipped. One DIV cycle is
                    // still spent, so the overflow done arrives two edges
                    // after start, with busy high for that one cycle.
                    if (p_reg >= d_reg) begin
                        ovf_pend <= 1'b1;
                        cnt      <= 4'd15;
                    end else begin
                        ovf_pend <= 1'b0;
                        cnt      <= 4'd0;
                    end
                end
                S_DIV: begin
                    if (!ovf_pend) begin
                        p_reg <= p_next;
                        l_reg <= {l_reg[14:0], q_bit};
                    end
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        if (ovf_pend) begin
                            quotient  <= 16'hFFFF;
                            remainder <= 16'hFFFF;
                            overflow  <= 1'b1;
                        end else begin
                            quotient  <= {l_reg[14:0], q_bit};
                            remainder <= p_next;
                            overflow  <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
